acondicionador_entrada: RTL and testbench



---
 rtl/acondicionador_entrada.sv | 78 +++++++
 tb/tb_acondicionador_entrada.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/acondicionador_entrada.sv
// acondicionador_entrada: multi-channel input conditioner for board pins.
// Each raw pin is brought into the clk domain by a two-flop synchroniser and
// debounced by a per-channel stability counter. The block delivers a clean
// level plus single-cycle rise/fall pulses aligned with the new level.
//
// Parameters:
//   WIDTH           number of independent channels
//   DEBOUNCE_CYCLES consecutive differing cycles needed to accept a change (>= 1)
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in          raw asynchronous pin levels
//   estado      debounced level per channel
//   pulso_sube  one-cycle pulse when estado[i] goes 0->1
//   pulso_baja  one-cycle pulse when estado[i] goes 1->0
// Build option:
//   ACOND_INVERTIR_EN  when defined, raw pins are inverted before the
//                      synchroniser (active-low buttons read as 1 when pressed)
module acondicionador_entrada #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] estado,
  output logic [WIDTH-1:0] pulso_sube,
  output logic [WIDTH-1:0] pulso_baja
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] in_eff;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt [WIDTH];

  // Optional polarity inversion ahead of the synchroniser
`ifdef ACOND_INVERTIR_EN
  assign in_eff = ~in;
`else
  assign in_eff = in;
`endif

  // Synchroniser, stability counters, debounced level and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      estado     <= '0;
      pulso_sube <= '0;
      pulso_baja <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= in_eff;
      s2 <= s1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        pulso_sube[i] <= 1'b0;
        pulso_baja[i] <= 1'b0;
        if (s2[i] == estado[i]) begin
          // Any return to the accepted level discards the candidate entirely
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          estado[i]     <= s2[i];
          cnt[i]        <= '0;
          pulso_sube[i] <= s2[i];
          pulso_baja[i] <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_acondicionador_entrada.sv
// Directed testbench for acondicionador_entrada (WIDTH=2, DEBOUNCE_CYCLES=4).
// Stimulus is expressed in logical (post-inversion) levels so the same vectors
// apply with or without ACOND_INVERTIR_EN.
module tb_acondicionador_entrada;

  localparam int unsigned W  = 2;
  localparam int unsigned DC = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in;
  logic [W-1:0] estado;
  logic [W-1:0] pulso_sube;
  logic [W-1:0] pulso_baja;

  int n_checks;
  int n_errors;

  acondicionador_entrada #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .estado     (estado),
    .pulso_sube (pulso_sube),
    .pulso_baja (pulso_baja)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logical level to raw pin level
  function automatic logic [W-1:0] raw(input logic [W-1:0] v);
`ifdef ACOND_INVERTIR_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge; sample/drive 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [W-1:0] exp_e);
    check({tag, " estado"}, 32'(estado), 32'(exp_e));
    check({tag, " sube"}, 32'(pulso_sube), 32'(0));
    check({tag, " baja"}, 32'(pulso_baja), 32'(0));
  endtask

  // Input already changed: expect 5 quiet edges, the change at edge 6, quiet edge 7
  task automatic expect_change(input string tag, input logic [W-1:0] old_e,
                               input logic [W-1:0] new_e, input logic [W-1:0] sube,
                               input logic [W-1:0] baja);
    for (int k = 1; k <= DC + 1; k++) begin
      tick();
      check_quiet({tag, " wait"}, old_e);
    end
    tick();
    check({tag, " new estado"}, 32'(estado), 32'(new_e));
    check({tag, " sube"}, 32'(pulso_sube), 32'(sube));
    check({tag, " baja"}, 32'(pulso_baja), 32'(baja));
    tick();
    check_quiet({tag, " after"}, new_e);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    in       = raw(2'b00);
    tick();
    tick();

    // Reset applies without a clock edge
    rst_n = 1'b0;
    #1;
    check_quiet("async reset", 2'b00);
    in = raw(2'b11);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_quiet("held reset", 2'b00);
    end
    rst_n = 1'b1;
    expect_change("post reset rise", 2'b00, 2'b11, 2'b11, 2'b00);

    in = raw(2'b00);
    expect_change("both fall", 2'b11, 2'b00, 2'b00, 2'b11);

    // Idle (raw high under inversion): no activity
    for (int k = 0; k < 8; k++) begin
      tick();
      check_quiet("idle", 2'b00);
    end

    // Latency and pulses on channel 0 only
    in = raw(2'b01);
    expect_change("ch0 rise", 2'b00, 2'b01, 2'b01, 2'b00);
    in = raw(2'b00);
    expect_change("ch0 fall", 2'b01, 2'b00, 2'b00, 2'b01);

    // Glitch of 3 cycles rejected
    in = raw(2'b01);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_quiet("glitch3 high", 2'b00);
    end
    in = raw(2'b00);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_quiet("glitch3 low", 2'b00);
    end

    // Toggle every 2 cycles for 40 cycles
    for (int k = 0; k < 40; k++) begin
      in = raw(((k / 2) % 2) == 0 ? 2'b01 : 2'b00);
      tick();
      check_quiet("toggle", 2'b00);
    end
    in = raw(2'b00);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_quiet("toggle settle", 2'b00);
    end

    // Boundary: exactly 4 cycles high is accepted, then falls
    in = raw(2'b01);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_quiet("bound high", 2'b00);
    end
    in = raw(2'b00);
    tick();
    check_quiet("bound e5", 2'b00);
    tick();
    check({"bound rise estado"}, 32'(estado), 32'(2'b01));
    check({"bound rise sube"}, 32'(pulso_sube), 32'(2'b01));
    check({"bound rise baja"}, 32'(pulso_baja), 32'(2'b00));
    for (int k = 7; k <= 9; k++) begin
      tick();
      check_quiet("bound hold", 2'b01);
    end
    tick();
    check({"bound fall estado"}, 32'(estado), 32'(2'b00));
    check({"bound fall sube"}, 32'(pulso_sube), 32'(2'b00));
    check({"bound fall baja"}, 32'(pulso_baja), 32'(2'b01));
    tick();
    check_quiet("bound after", 2'b00);

    // Reset mid-count discards the candidate
    in = raw(2'b10);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_quiet("midcount", 2'b00);
    end
    rst_n = 1'b0;
    #1;
    check_quiet("midcount reset", 2'b00);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_quiet("midcount held", 2'b00);
    end
    rst_n = 1'b1;
    expect_change("midcount release", 2'b00, 2'b10, 2'b10, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
